// File: rtl/ctrl_pipe_unit.sv
// PCPU ID-stage control: decode into the ID/EX bundle, load-use and MDU stalls,
// redirect flush, and the multiply/divide latency sequencer.
module ctrl_pipe_unit #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int RA_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            id_valid,
  input  logic            ex_redirect,
  output logic [3:0]      ex_pcwritecond,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_regdata,
  output logic            ex_alusrca,
  output logic            ex_alusrcb,
  output logic            ex_regwrite,
  output logic [1:0]      ex_jump,
  output logic [1:0]      ex_link,
  output logic [1:0]      ex_extop,
  output logic [3:0]      ex_aluop,
  output logic [RA_W-1:0] ex_wreg,
  output logic            ex_illegal,
  output logic            mdu_start,
  output logic [1:0]      mdu_op,
  output logic            mdu_busy,
  output logic            pc_stall,
  output logic            if_flush
);

  localparam int CW = $clog2(DIV_LAT + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
                         OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LB    = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23, OP_LBU  = 6'h24,
                         OP_LHU   = 6'h25, OP_SB     = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

  localparam logic [3:0] COND_BEQ = 4'd1, COND_BNE = 4'd2, COND_BLEZ = 4'd3, COND_BGTZ = 4'd4,
                         COND_BLTZ = 4'd5, COND_BGEZ = 4'd6;

  localparam logic [3:0] ALUOP_NOP = 4'd0, ALUOP_R = 4'd1, ALUOP_ADD = 4'd2, ALUOP_ADDU = 4'd3,
                         ALUOP_SLT = 4'd4, ALUOP_SLTU = 4'd5, ALUOP_AND = 4'd6, ALUOP_OR = 4'd7,
                         ALUOP_XOR = 4'd8, ALUOP_LUI = 4'd9, ALUOP_SUB = 4'd10;

  localparam logic [1:0] EXTOP_ARITH = 2'b01, EXTOP_LOGIC = 2'b10;
  localparam logic [1:0] JMP_ABS = 2'b01, JMP_REG = 2'b11;
  localparam logic [1:0] LNK_R31 = 2'b01, LNK_RD = 2'b10;

  typedef struct packed {
    logic [3:0]      pcwritecond;
    logic            memread;
    logic            memwrite;
    logic            regdata;
    logic            alusrca;
    logic            alusrcb;
    logic            regwrite;
    logic [1:0]      jump;
    logic [1:0]      link;
    logic [1:0]      extop;
    logic [3:0]      aluop;
    logic [RA_W-1:0] wreg;
    logic            illegal;
  } ctrl_t;

  logic [5:0]      opc, fn;
  logic [RA_W-1:0] ra_rs, ra_rt, ra_rd;
  ctrl_t           dec, ex_d, ex_q;
  logic            is_mdu, is_mfx, reads_rt, bad_op;
  logic            load_use, mdu_hz, issue;
  logic [CW-1:0]   cnt_d, cnt_q;
  logic            start_d, start_q;
  logic [1:0]      op_d, op_q;
  logic            unused_shamt;

  assign opc   = instr[31:26];
  assign fn    = instr[5:0];
  assign ra_rs = RA_W'(instr[25:21]);
  assign ra_rt = RA_W'(instr[20:16]);
  assign ra_rd = RA_W'(instr[15:11]);
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    dec      = '0;
    is_mdu   = 1'b0;
    is_mfx   = 1'b0;
    reads_rt = 1'b0;
    bad_op   = 1'b0;
    case (opc)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        case (fn)
          6'h00, 6'h02, 6'h03: begin
            dec.aluop = ALUOP_R; dec.regwrite = 1'b1; dec.wreg = ra_rd; dec.alusrca = 1'b1;
          end
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            dec.aluop = ALUOP_R; dec.regwrite = 1'b1; dec.wreg = ra_rd;
          end
          6'h08: dec.jump = JMP_REG;
          6'h09: begin
            dec.jump = JMP_REG; dec.link = LNK_RD; dec.regwrite = 1'b1; dec.wreg = ra_rd;
          end
          6'h10, 6'h12: begin
            is_mfx = 1'b1; dec.regwrite = 1'b1; dec.wreg = ra_rd; dec.aluop = ALUOP_NOP;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: is_mdu = 1'b1;
          default: bad_op = 1'b1;
        endcase
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        dec.extop = EXTOP_ARITH;
        dec.aluop = ALUOP_SUB;
        case (opc)
          OP_BEQ:  begin dec.pcwritecond = COND_BEQ; reads_rt = 1'b1; end
          OP_BNE:  begin dec.pcwritecond = COND_BNE; reads_rt = 1'b1; end
          OP_BLEZ: dec.pcwritecond = COND_BLEZ;
          OP_BGTZ: dec.pcwritecond = COND_BGTZ;
          default: dec.pcwritecond = instr[16] ? COND_BGEZ : COND_BLTZ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.alusrcb  = 1'b1;
        dec.regwrite = 1'b1;
        dec.wreg     = ra_rt;
        dec.extop    = opc[2] ? EXTOP_LOGIC : EXTOP_ARITH;
        case (opc)
          OP_ADDI:  dec.aluop = ALUOP_ADD;
          OP_ADDIU: dec.aluop = ALUOP_ADDU;
          OP_SLTI:  dec.aluop = ALUOP_SLT;
          OP_SLTIU: dec.aluop = ALUOP_SLTU;
          OP_ANDI:  dec.aluop = ALUOP_AND;
          OP_ORI:   dec.aluop = ALUOP_OR;
          OP_XORI:  dec.aluop = ALUOP_XOR;
          default:  dec.aluop = ALUOP_LUI;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dec.memread = 1'b1; dec.regdata = 1'b1; dec.aluop = ALUOP_ADD; dec.extop = EXTOP_ARITH;
        dec.alusrcb = 1'b1; dec.regwrite = 1'b1; dec.wreg = ra_rt;
      end
      OP_SB, OP_SH, OP_SW: begin
        reads_rt = 1'b1;
        dec.memwrite = 1'b1; dec.aluop = ALUOP_ADD; dec.extop = EXTOP_ARITH; dec.alusrcb = 1'b1;
      end
      OP_J:   dec.jump = JMP_ABS;
      OP_JAL: begin
        dec.jump = JMP_ABS; dec.link = LNK_R31; dec.regwrite = 1'b1; dec.wreg = {RA_W{1'b1}};
      end
      default: bad_op = 1'b1;
    endcase
    // $0 is never a real destination
    if (dec.wreg == '0) dec.regwrite = 1'b0;
    if (bad_op) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // Hazards look at the bundle already in EX, i.e. the instruction one ahead.
  assign load_use = ex_q.memread && (ex_q.wreg != '0) &&
                    ((ex_q.wreg == ra_rs) || (reads_rt && (ex_q.wreg == ra_rt)));
  assign mdu_hz   = mdu_busy && (is_mdu || is_mfx);
  assign pc_stall = id_valid && !ex_redirect && (load_use || mdu_hz);
  assign if_flush = ex_redirect;
  assign issue    = id_valid && !ex_redirect && !pc_stall && is_mdu;
  assign mdu_busy = (cnt_q != '0);

  always_comb begin
    ex_d    = '0;
    start_d = issue;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (!ex_redirect && !pc_stall && id_valid) ex_d = dec;
    if (issue) begin
      op_d  = fn[1:0];
      cnt_d = fn[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q    <= '0;
      start_q <= 1'b0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      start_q <= start_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_pcwritecond = ex_q.pcwritecond;
  assign ex_memread     = ex_q.memread;
  assign ex_memwrite    = ex_q.memwrite;
  assign ex_regdata     = ex_q.regdata;
  assign ex_alusrca     = ex_q.alusrca;
  assign ex_alusrcb     = ex_q.alusrcb;
  assign ex_regwrite    = ex_q.regwrite;
  assign ex_jump        = ex_q.jump;
  assign ex_link        = ex_q.link;
  assign ex_extop       = ex_q.extop;
  assign ex_aluop       = ex_q.aluop;
  assign ex_wreg        = ex_q.wreg;
  assign ex_illegal     = ex_q.illegal;
  assign mdu_start      = start_q;
  assign mdu_op         = op_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed + random bench for ctrl_pipe_unit against a table-level reference model.
module tb_ctrl_pipe_unit;
  localparam int ML = 4;
  localparam int DL = 32;

  logic        clk, rst, id_valid, ex_redirect;
  logic [31:0] instr;
  logic [3:0]  ex_pcwritecond, ex_aluop;
  logic        ex_memread, ex_memwrite, ex_regdata, ex_alusrca, ex_alusrcb, ex_regwrite;
  logic [1:0]  ex_jump, ex_link, ex_extop, mdu_op;
  logic [4:0]  ex_wreg;
  logic        ex_illegal, mdu_start, mdu_busy, pc_stall, if_flush;

  ctrl_pipe_unit #(.MULT_LAT(ML), .DIV_LAT(DL), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid), .ex_redirect(ex_redirect),
    .ex_pcwritecond(ex_pcwritecond), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regdata(ex_regdata), .ex_alusrca(ex_alusrca), .ex_alusrcb(ex_alusrcb),
    .ex_regwrite(ex_regwrite), .ex_jump(ex_jump), .ex_link(ex_link), .ex_extop(ex_extop),
    .ex_aluop(ex_aluop), .ex_wreg(ex_wreg), .ex_illegal(ex_illegal), .mdu_start(mdu_start),
    .mdu_op(mdu_op), .mdu_busy(mdu_busy), .pc_stall(pc_stall), .if_flush(if_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cond;
    logic       mr, mw, rd, asa, asb, rw;
    logic [1:0] jmp, lnk, ext;
    logic [3:0] aop;
    logic [4:0] wreg;
    logic       ill;
  } bun_t;

  int   total = 0, bad = 0, cyc = 0;
  bun_t m_ex;
  logic m_start;
  logic [1:0] m_op;
  int   m_iss_cyc, m_iss_lat;
  logic obs_stall, obs_flush;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Expected bundle straight from the instruction-class tables.
  function automatic bun_t ref_dec(input logic [31:0] i, output bit mdu, output bit mfx,
                                   output bit rrt);
    bun_t b;
    int op, fn;
    bit is_r, shf, alu_r, jr, jalr, br, imm_a, imm_l, ld, st, jj, jal;
    op = int'(i[31:26]); fn = int'(i[5:0]);
    is_r  = (op == 0);
    shf   = is_r && (fn inside {0, 2, 3});
    alu_r = is_r && (fn inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43});
    jr    = is_r && fn == 8;
    jalr  = is_r && fn == 9;
    mfx   = is_r && (fn inside {16, 18});
    mdu   = is_r && (fn inside {[24:27]});
    br    = op inside {1, [4:7]};
    imm_a = op inside {[8:11]};
    imm_l = op inside {[12:15]};
    ld    = op inside {32, 33, 35, 36, 37};
    st    = op inside {40, 41, 43};
    jj    = (op == 2);
    jal   = (op == 3);
    rrt   = is_r || op == 4 || op == 5 || st;
    b = '0;
    if (!(alu_r || jr || jalr || mfx || mdu || br || imm_a || imm_l || ld || st || jj || jal)) begin
      b.ill = 1'b1;
      mdu = 0; mfx = 0;
      return b;
    end
    b.cond = (op == 1) ? 4'(5 + int'(i[16])) : (br ? 4'(op - 3) : 4'd0);
    b.mr   = ld;
    b.rd   = ld;
    b.mw   = st;
    b.asa  = shf;
    b.asb  = imm_a || imm_l || ld || st;
    b.rw   = alu_r || jalr || mfx || imm_a || imm_l || ld || jal;
    b.jmp  = (jr || jalr) ? 2'd3 : ((jj || jal) ? 2'd1 : 2'd0);
    b.lnk  = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
    b.ext  = (br || imm_a || ld || st) ? 2'd1 : (imm_l ? 2'd2 : 2'd0);
    b.aop  = alu_r ? 4'd1 : ((imm_a || imm_l) ? 4'(op - 6) : ((ld || st) ? 4'd2 : (br ? 4'd10 : 4'd0)));
    b.wreg = !b.rw ? 5'd0 : (is_r ? i[15:11] : (jal ? 5'd31 : i[20:16]));
    if (b.wreg == 0) b.rw = 1'b0;
    return b;
  endfunction

  function automatic bit m_busy();
    return (m_iss_lat > 0) && ((cyc - m_iss_cyc) < m_iss_lat);
  endfunction

  // One clock: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit r, input logic [31:0] ins, input bit v, input bit red);
    bun_t d, o;
    bit mdu, mfx, rrt, lu, stl, acc;
    rst = r; instr = ins; id_valid = v; ex_redirect = red;
    #1;
    d   = ref_dec(ins, mdu, mfx, rrt);
    lu  = m_ex.mr && m_ex.wreg != 0 &&
          (m_ex.wreg == ins[25:21] || (rrt && m_ex.wreg == ins[20:16]));
    stl = v && !red && (lu || (m_busy() && (mdu || mfx)));
    chk("pc_stall", pc_stall, stl);
    chk("if_flush", if_flush, red);
    obs_stall = pc_stall;
    obs_flush = if_flush;
    @(posedge clk);
    cyc++;
    if (!r) begin
      m_ex = '0; m_start = 0; m_op = 0; m_iss_lat = 0;
    end else begin
      acc     = v && !red && !stl;
      m_ex    = acc ? d : '0;
      m_start = acc && mdu;
      if (m_start) begin
        m_op      = ins[1:0];
        m_iss_cyc = cyc;
        m_iss_lat = ins[1] ? DL : ML;
      end
    end
    #1;
    o = {ex_pcwritecond, ex_memread, ex_memwrite, ex_regdata, ex_alusrca, ex_alusrcb,
         ex_regwrite, ex_jump, ex_link, ex_extop, ex_aluop, ex_wreg, ex_illegal};
    chk("bundle", o, m_ex);
    chk("mdu_start", mdu_start, m_start);
    chk("mdu_op", mdu_op, m_op);
    chk("mdu_busy", mdu_busy, m_busy());
  endtask

  function automatic logic [31:0] rt_i(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] it_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rand_instr();
    int ops [32] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                     12, 13, 14, 15, 32, 33, 35, 35, 35, 36, 37, 40, 41, 43, 63, 17};
    int fns [22] = '{0, 2, 3, 4, 6, 7, 8, 9, 16, 18, 32, 33, 34, 35, 36, 37,
                     38, 39, 42, 43, 1, 24};
    logic [31:0] w;
    int op;
    op = ops[$urandom_range(0, 31)];
    w  = {6'(op), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
    if (op == 0) begin
      w[15:11] = 5'($urandom_range(0, 3));
      w[5:0]   = 6'(fns[$urandom_range(0, 21)]);
      if (w[5:0] == 6'd24) w[5:0] = 6'(24 + $urandom_range(0, 3));
    end
    return w;
  endfunction

  initial begin
    logic [31:0] lw8, add10, cur;
    int n, nb;
    bit done;
    rst = 0; instr = 0; id_valid = 0; ex_redirect = 0;
    m_ex = '0; m_start = 0; m_op = 0; m_iss_cyc = 0; m_iss_lat = 0;
    @(posedge clk); #1;
    lw8   = it_i(35, 9, 8, 0);
    add10 = rt_i(8, 11, 10, 32);

    // reset holds everything at zero even with a load in ID
    step(0, lw8, 1, 0); chk("rst_memread", ex_memread, 0);
    step(0, lw8, 1, 0); chk("rst_wreg", ex_wreg, 0);
    step(1, lw8, 1, 0); chk("lw_memread", ex_memread, 1); chk("lw_wreg", ex_wreg, 8);

    // load-use: one stall, one bubble
    step(1, add10, 1, 0); chk("lu_stall", obs_stall, 1); chk("lu_bubble", ex_memread, 0);
    step(1, add10, 1, 0); chk("lu_release", obs_stall, 0);
    chk("add_rw", ex_regwrite, 1); chk("add_wreg", ex_wreg, 10);
    step(1, it_i(35, 9, 0, 0), 1, 0); chk("lw0_rw", ex_regwrite, 0);
    step(1, rt_i(0, 11, 10, 32), 1, 0); chk("lw0_nostall", obs_stall, 0);

    // div then dependent mflo
    step(1, rt_i(8, 9, 0, 26), 1, 0); chk("div_start", mdu_start, 1); chk("div_op", mdu_op, 2);
    n = 0; nb = 1; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      step(1, rt_i(0, 0, 12, 18), 1, 0);
      if (obs_stall) n++; else done = 1;
      if (mdu_busy) nb++;
    end
    chk("div_stall_len", n, DL); chk("div_busy_len", nb, DL);
    chk("mflo_wreg", ex_wreg, 12); chk("mflo_rw", ex_regwrite, 1);

    // mult then dependent mfhi
    step(1, rt_i(8, 9, 0, 24), 1, 0); chk("mult_start", mdu_start, 1);
    n = 0; done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      step(1, rt_i(0, 0, 13, 16), 1, 0);
      if (obs_stall) n++; else done = 1;
    end
    chk("mult_stall_len", n, ML); chk("mfhi_wreg", ex_wreg, 13);

    // redirect beats a live load-use hazard
    step(1, lw8, 1, 0);
    step(1, it_i(4, 8, 9, 4), 1, 1);
    chk("redir_flush", obs_flush, 1); chk("redir_nostall", obs_stall, 0);
    chk("redir_bubble", ex_pcwritecond, 0);
    step(1, rt_i(8, 9, 0, 27), 1, 1);
    chk("redir_nostart", mdu_start, 0); chk("redir_nobusy", mdu_busy, 0);

    // decode sweep
    step(1, {6'd3, 26'h10}, 1, 0);
    chk("jal_jump", ex_jump, 1); chk("jal_link", ex_link, 1);
    chk("jal_wreg", ex_wreg, 31); chk("jal_rw", ex_regwrite, 1);
    step(1, it_i(1, 5, 1, 8), 1, 0); chk("bgez_cond", ex_pcwritecond, 6);
    step(1, it_i(1, 5, 0, 8), 1, 0); chk("bltz_cond", ex_pcwritecond, 5);
    step(1, rt_i(0, 5, 6, 3), 1, 0); chk("sra_asa", ex_alusrca, 1);
    step(1, 32'hFC00_0000, 1, 0); chk("ill_flag", ex_illegal, 1); chk("ill_rw", ex_regwrite, 0);

    // reset in the middle of a divide
    step(1, rt_i(8, 9, 0, 26), 1, 0);
    step(1, add10, 1, 0);
    step(1, add10, 1, 0);
    step(0, add10, 1, 0); chk("rst_mdu_busy", mdu_busy, 0);
    step(1, add10, 1, 0); chk("post_rst_wreg", ex_wreg, 10);

    // random stream; a stalled instruction stays in ID
    cur = rand_instr();
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) != 0), cur, ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) == 0));
      if (!obs_stall) cur = rand_instr();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined control unit for the PCPU. It decodes the ID-stage instruction and registers the result into the ID/EX control bundle. It also generates load-use stalls and redirect flushes, and sequences the multi-cycle multiply/divide unit (MDU) with a parametrised latency counter. It sits between the IF/ID register and the EX-stage datapath muxes, and drives the PC/IF-ID hold and flush controls.

## Interface
- MULT_LAT, 4: cycles mult/multu occupy the MDU (≥2)
- DIV_LAT, 32: cycles div/divu occupy the MDU (≥2, ≥MULT_LAT)
- RA_W, 5: register-address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- instr  in  32  ID-stage instruction
- id_valid  in  1  instr holds a real instruction
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- ex_pcwritecond  out  4  branch condition (`COND_*` from Brch_defines.v)
- ex_memread, ex_memwrite, ex_regdata, ex_alusrca, ex_alusrcb, ex_regwrite  out  1 each  datapath controls
- ex_jump, ex_link, ex_extop  out  2 each  jump/link/extend select
- ex_aluop  out  4  `ALUOP_*` from ALU_defines.v
- ex_wreg  out  RA_W  resolved destination register
- ex_illegal  out  1  unrecognised opcode/funct issued
- mdu_start  out  1  one-cycle MDU launch, aligned with the bundle
- mdu_op  out  2  00 mult, 01 multu, 10 div, 11 divu
- mdu_busy  out  1  MDU occupied
- pc_stall  out  1  hold PC and IF/ID (combinational)
- if_flush  out  1  clear IF/ID (combinational, equals ex_redirect)

## Operation
- Decode (combinational, in ID); opcodes come from Instr_defines.v.
  - R-type: ALUOP_R, RegWrite, wreg=rd. sll/srl/sra (funct 00/02/03) set alusrca=1.
  - jr: jump=11, no write. jalr: jump=11, link=10, RegWrite=1, wreg=rd.
  - beq/bne/blez/bgtz/bltz/bgez: condition from opcode. REGIMM uses instr[16] (1→BGEZ, 0→BLTZ). EXTOP_ARITH, no write.
  - addi/addiu/slti/sltiu: matching ALUOP, EXTOP_ARITH, alusrcb=1, wreg=rt.
  - andi/ori/xori/lui: matching ALUOP, EXTOP_LOGIC, alusrcb=1, wreg=rt.
  - lb/lbu/lh/lhu/lw: memread, regdata, ALUOP_ADD, EXTOP_ARITH, alusrcb=1, RegWrite, wreg=rt.
  - sb/sh/sw: memwrite, ALUOP_ADD, EXTOP_ARITH, alusrcb=1.
  - j: jump=01. jal: jump=01, link=01, RegWrite=1, wreg=31.
  - mult/multu/div/divu (funct 18–1B): MDU issue, no RF write. mfhi/mflo (funct 10/12): RegWrite, wreg=rd, ALUOP_NOP.
  - Anything else: bubble with illegal=1.
  - wreg=0 forces RegWrite=0.
- Bubble: all bundle outputs 0.
- Load-use hazard: ex_memread && ex_wreg≠0 && (ex_wreg==rs || (ex_wreg==rt && instr reads rt)). Instructions that read rt: R-type, beq/bne, stores.
- MDU hazard: mdu_busy && ID holds mult/multu/div/divu/mfhi/mflo.
- pc_stall = id_valid && !ex_redirect && (load-use || MDU hazard).
- ID/EX register load priority: !rst → zero; else ex_redirect → bubble; else pc_stall or !id_valid → bubble; else decoded bundle.
- MDU counter, width $clog2(DIV_LAT+1):
  - On an accepted MDU issue, load MULT_LAT or DIV_LAT and assert mdu_start and mdu_op.
  - Decrement while nonzero. mdu_busy = counter≠0.
  - A redirect never cancels a running op (it belongs to an older instruction).

## Timing
- Reset: every output 0, counter 0, on the first clk edge with rst=0.
- Decode-to-bundle latency is 1 cycle. mdu_start is high exactly 1 cycle.
- mdu_busy rises on the same edge as mdu_start and stays high exactly LAT cycles. A dependent mfhi enters EX the cycle after busy falls.
- A load-use stall lasts exactly 1 cycle; the next cycle ex_memread is 0.
- Simultaneous redirect + stall: the redirect wins, pc_stall=0, bubble is inserted.
- Redirect with an MDU op in ID: no start, counter unchanged.
- rst low mid-MDU: busy clears at that edge; the cycle after rst rises, the bundle reflects ID.

## Test plan
- Reset: rst=0 for 2 cycles with lw in ID → all outputs 0. Release → the next edge gives ex_memread=1, ex_wreg=rt.
- Load-use: `lw $8,0($9)` then `add $10,$8,$11` → pc_stall=1 for 1 cycle, one bubble, then add with ex_regwrite=1 and ex_wreg=10. Repeating with `$0` as lw's destination gives no stall.
- MDU: div issued, then mflo → mdu_busy high 32 cycles, mflo stalled 32 cycles, mflo reaches EX on cycle 33. mult with MULT_LAT=4 → 4 cycles.
- Redirect: ex_redirect=1 while beq is in ID and a load-use hazard is active → if_flush=1, pc_stall=0, bubble. A div in ID during the redirect → mdu_start stays 0.
- Decode sweep: jal → jump=01, link=01, wreg=31, regwrite=1. REGIMM with instr[16]=1 → COND_BGEZ. sra → alusrca=1. Opcode 0x3F → ex_illegal=1, ex_regwrite=0.
